// File: rtl/factorization12_search.sv
// factorization12_search: sequential search for the smallest non-trivial factor
// pair f1 * f2 == n with 2 <= f1 <= f2 <= 63. Each candidate divisor p is tested
// by a 12-cycle bit-serial restoring division followed by a one-cycle decision.
module factorization12_search #(
    parameter int W_N = 12,
    parameter int W_F = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W_N-1:0] n,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           found,
    output logic [W_F-1:0] f1,
    output logic [W_F-1:0] f2,
    output logic           busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0]     BIT_MSB = 4'(W_N - 1);
    localparam logic [W_F-1:0] P_FIRST = W_F'(2);
    localparam logic [W_F-1:0] P_LAST  = {W_F{1'b1}};
    localparam logic [W_N-1:0] Q_MAX   = {{(W_N-W_F){1'b0}}, {W_F{1'b1}}};

    state_t         state_q, state_d;
    logic [W_N-1:0] n_q, n_d;
    logic [W_F-1:0] p_q, p_d;
    logic [W_F:0]   r_q, r_d;
    logic [W_N-1:0] q_q, q_d;
    logic [3:0]     bitcnt_q, bitcnt_d;
    logic           found_q, found_d;
    logic [W_F-1:0] f1_q, f1_d;
    logic [W_F-1:0] f2_q, f2_d;

    logic [W_F+1:0] step;
    logic [W_N-1:0] p_ext;

    // One restoring-division step: returns {quotient bit, new remainder}.
    // The remainder stays below p, so its low W_F bits carry all information.
    function automatic logic [W_F+1:0] div_step(input logic [W_F:0]   r_in,
                                                 input logic           n_bit,
                                                 input logic [W_F-1:0] d);
        logic [W_F:0] r_sh;
        r_sh = {r_in[W_F-1:0], n_bit};
        if (r_sh >= {1'b0, d})
            div_step = {1'b1, r_sh - {1'b0, d}};
        else
            div_step = {1'b0, r_sh};
    endfunction

    assign step  = div_step(r_q, n_q[bitcnt_q], p_q);
    assign p_ext = {{(W_N-W_F){1'b0}}, p_q};

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_DIV) || (state_q == S_CHECK);
    assign found     = found_q;
    assign f1        = f1_q;
    assign f2        = f2_q;

    // Next-state logic: accept, divide one bit per cycle, decide per candidate, hand off.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        p_d      = p_q;
        r_d      = r_q;
        q_d      = q_q;
        bitcnt_d = bitcnt_q;
        found_d  = found_q;
        f1_d     = f1_q;
        f2_d     = f2_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    n_d      = n;
                    p_d      = P_FIRST;
                    r_d      = '0;
                    q_d      = '0;
                    bitcnt_d = BIT_MSB;
                    state_d  = S_DIV;
                end
            end
            S_DIV: begin
                r_d           = step[W_F:0];
                q_d[bitcnt_q] = step[W_F+1];
                if (bitcnt_q == 4'd0)
                    state_d = S_CHECK;
                else
                    bitcnt_d = bitcnt_q - 4'd1;
            end
            S_CHECK: begin
                if ((r_q == '0) && (q_q >= p_ext) && (q_q <= Q_MAX)) begin
                    found_d = 1'b1;
                    f1_d    = p_q;
                    f2_d    = q_q[W_F-1:0];
                    state_d = S_DONE;
                end else if ((q_q < p_ext) || (p_q == P_LAST)) begin
                    // Either p*p > n, or the last candidate is exhausted.
                    found_d = 1'b0;
                    f1_d    = '0;
                    f2_d    = '0;
                    state_d = S_DONE;
                end else begin
                    p_d      = p_q + W_F'(1);
                    r_d      = '0;
                    q_d      = '0;
                    bitcnt_d = BIT_MSB;
                    state_d  = S_DIV;
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any search in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            p_q      <= '0;
            r_q      <= '0;
            q_q      <= '0;
            bitcnt_q <= '0;
            found_q  <= 1'b0;
            f1_q     <= '0;
            f2_q     <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            p_q      <= p_d;
            r_q      <= r_d;
            q_q      <= q_d;
            bitcnt_q <= bitcnt_d;
            found_q  <= found_d;
            f1_q     <= f1_d;
            f2_q     <= f2_d;
        end
    end

endmodule

// File: tb/tb_factorization12_search.sv
// Directed-vector bench for factorization12_search, plus a short random sample
// checked against a reference factor search and the pair-acceptance rule.
module tb_factorization12_search;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] n = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        found;
    logic [5:0]  f1;
    logic [5:0]  f2;
    logic        busy;

    int checks = 0;
    int errors = 0;

    factorization12_search dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .found     (found),
        .f1        (f1),
        .f2        (f2),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Smallest p in 2..63 with p | n and p <= n/p <= 63, plus the cycle at
    // which the result first appears (13 cycles per candidate tested, +1).
    function automatic void ref_model(input int nv, output int fnd, output int a,
                                      output int b, output int lat);
        int q;
        int r;
        fnd = 0; a = 0; b = 0; lat = 13 * 62 + 1;
        for (int p = 2; p <= 63; p++) begin
            q = nv / p;
            r = nv % p;
            if (r == 0 && q >= p && q <= 63) begin
                fnd = 1; a = p; b = q; lat = 13 * (p - 1) + 1;
                return;
            end
            if (q < p) begin
                lat = 13 * (p - 1) + 1;
                return;
            end
        end
    endfunction

    task automatic run_req(input string tag, input int nv, input int ef,
                           input int ea, input int eb, input int elat);
        int cyc;
        int w;
        w = 0;
        while (!in_ready && w < 2000) begin
            @(posedge clk); #1; w++;
        end
        check({tag, "_idle"}, int'(in_ready), 1);
        in_valid  = 1'b1;
        n         = nv[11:0];
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        check({tag, "_busy"}, int'(busy), 1);
        check({tag, "_inrdy_lo"}, int'(in_ready), 0);
        while (!out_valid && cyc < 1000) begin
            @(posedge clk); #1; cyc++;
        end
        check({tag, "_lat"}, cyc, elat);
        check({tag, "_found"}, int'(found), ef);
        check({tag, "_f1"}, int'(f1), ea);
        check({tag, "_f2"}, int'(f2), eb);
        if (found)
            check({tag, "_pairok"},
                  int'((int'(f1) * int'(f2) == nv) && f1 != 6'd1 && f2 != 6'd1), 1);
        @(posedge clk); #1;
        check({tag, "_ovld_lo"}, int'(out_valid), 0);
        check({tag, "_inrdy_hi"}, int'(in_ready), 1);
    endtask

    initial begin
        int ef, ea, eb, el, nv, w;

        // Reset state
        #2;
        check("rst_inrdy", int'(in_ready), 1);
        check("rst_ovld", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_found", int'(found), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors
        run_req("n6", 6, 1, 2, 3, 14);
        run_req("n4", 4, 1, 2, 2, 14);
        run_req("n7", 7, 0, 0, 0, 27);
        run_req("n0", 0, 0, 0, 0, 14);
        run_req("n2", 2, 0, 0, 0, 14);
        run_req("n3969", 3969, 1, 63, 63, 807);
        run_req("n4095", 4095, 0, 0, 0, 807);

        // Asynchronous reset in the middle of a division
        run_req("n6a", 6, 1, 2, 3, 14);
        in_valid = 1'b1; n = 12'd4095;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_ovld", int'(out_valid), 0);
        check("arst_inrdy", int'(in_ready), 1);
        check("arst_busy", int'(busy), 0);
        check("arst_found", int'(found), 0);
        check("arst_f1", int'(f1), 0);
        check("arst_f2", int'(f2), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_req("n6b", 6, 1, 2, 3, 14);

        // Backpressure on the result, with ignored request pulses
        in_valid = 1'b1; n = 12'd35; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 1;
        while (!out_valid && w < 1000) begin
            @(posedge clk); #1; w++;
        end
        check("bp_lat", w, 53);
        for (int i = 0; i < 20; i++) begin
            check("bp_ovld", int'(out_valid), 1);
            check("bp_found", int'(found), 1);
            check("bp_f1", int'(f1), 5);
            check("bp_f2", int'(f2), 7);
            check("bp_inrdy", int'(in_ready), 0);
            in_valid = (i % 2 == 0);
            n = 12'd6;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_ovld_lo", int'(out_valid), 0);
        check("bp_inrdy_hi", int'(in_ready), 1);
        check("bp_busy", int'(busy), 0);

        // Random sample against the reference search
        for (int i = 0; i < 40; i++) begin
            nv = int'($urandom_range(0, 4095));
            ref_model(nv, ef, ea, eb, el);
            run_req($sformatf("rnd%0d", nv), nv, ef, ea, eb, el);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
